// File: rtl/fpaccum.sv
// fpaccum: sums k fixed-point products, shifts by avg_shift, wraps or clamps (FPACCUM_SATURATE_EN) to n bits
module fpaccum #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int k = 4,
  parameter int sign = 1,
  parameter int avg_shift = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snd_val,
  output logic         snd_rdy,
  input  logic [n-1:0] a,
  output logic         rcv_val,
  input  logic         rcv_rdy,
  output logic [n-1:0] c
);
  localparam int g = $clog2(k + 1);
  localparam int w = n + g;
  typedef enum logic {ACCUM, DONE} state_t;
  state_t state;
  logic [w-1:0] acc, ext_a, sum, sh;
  logic [g-1:0] count;
  logic [n-1:0] res;
  if (k < 1 || avg_shift < 0 || avg_shift > g || d < 0 || d > n) begin : g_bad_cfg
    $error("fpaccum: invalid parameters");
  end
  assign ext_a = sign != 0 ? {{g{a[n-1]}}, a} : {{g{1'b0}}, a};
  assign sum = acc + ext_a;
  assign sh = sign != 0 ? w'($signed(sum) >>> avg_shift) : sum >> avg_shift;
`ifdef FPACCUM_SATURATE_EN
  logic ovf;
  assign ovf = sign != 0 ? (sh[w-1:n-1] != {(g+1){sh[w-1]}}) : (sh[w-1:n] != '0);
  assign res = !ovf ? sh[n-1:0] : sign != 0 ? {sh[w-1], {(n-1){~sh[w-1]}}} : '1;
`else
  assign res = sh[n-1:0];
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      state <= ACCUM;
      snd_rdy <= 1'b1;
      rcv_val <= 1'b0;
      c <= '0;
      acc <= '0;
      count <= '0;
    end else if (state == ACCUM) begin
      if (snd_val && snd_rdy) begin
        if (count == g'(k - 1)) begin
          c <= res;
          rcv_val <= 1'b1;
          snd_rdy <= 1'b0;
          state <= DONE;
        end else begin
          acc <= sum;
          count <= count + g'(1);
        end
      end
    end else if (rcv_val && rcv_rdy) begin
      rcv_val <= 1'b0;
      snd_rdy <= 1'b1;
      acc <= '0;
      count <= '0;
      state <= ACCUM;
    end
endmodule

// File: tb/tb_fpaccum.sv
// tb_fpaccum: random and directed checks of fpaccum (shift 0 and 2) against a transaction-level sum model
module tb_fpaccum;
  logic clk = 1'b0, reset = 1'b0, snd_val = 1'b0, rcv_rdy = 1'b0;
  logic [15:0] a = '0, c0, c1;
  logic snd_rdy0, rcv_val0, snd_rdy1, rcv_val1;
  int errors = 0, checks = 0;
  logic [15:0] q[$];
  bit done = 0;
  logic [15:0] e0 = '0, e1 = '0;
  always #5 clk = ~clk;
  fpaccum #(.n(16), .d(8), .k(4), .sign(1), .avg_shift(0)) u0 (
    .clk(clk), .reset(reset), .snd_val(snd_val), .snd_rdy(snd_rdy0), .a(a),
    .rcv_val(rcv_val0), .rcv_rdy(rcv_rdy), .c(c0)
  );
  fpaccum #(.n(16), .d(8), .k(4), .sign(1), .avg_shift(2)) u1 (
    .clk(clk), .reset(reset), .snd_val(snd_val), .snd_rdy(snd_rdy1), .a(a),
    .rcv_val(rcv_val1), .rcv_rdy(rcv_rdy), .c(c1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] reduce(input int shift);
    longint s = 0;
    foreach (q[i]) s += longint'($signed(q[i]));
    s = s >>> shift;
`ifdef FPACCUM_SATURATE_EN
    s = s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`endif
    return s[15:0];
  endfunction
  task automatic step(input bit r, input bit sv, input logic [15:0] av, input bit rr);
    @(negedge clk);
    reset = r;
    snd_val = sv;
    a = av;
    rcv_rdy = rr;
    if (!r) begin
      q.delete();
      done = 0;
      e0 = '0;
      e1 = '0;
    end else if (!done) begin
      if (sv) begin
        q.push_back(av);
        if (q.size() == 4) begin
          e0 = reduce(0);
          e1 = reduce(2);
          done = 1;
          q.delete();
        end
      end
    end else if (rr) done = 0;
    @(posedge clk);
    #1;
    check("snd_rdy0", 32'(snd_rdy0), 32'(!done));
    check("rcv_val0", 32'(rcv_val0), 32'(done));
    check("snd_rdy1", 32'(snd_rdy1), 32'(!done));
    check("rcv_val1", 32'(rcv_val1), 32'(done));
    check("c0", 32'(c0), 32'(e0));
    check("c1", 32'(c1), 32'(e1));
  endtask
  task automatic group4(input logic [15:0] v0, input logic [15:0] v1, input logic [15:0] v2, input logic [15:0] v3);
    step(1, 1, v0, 1);
    step(1, 1, v1, 1);
    step(1, 1, v2, 1);
    step(1, 1, v3, 1);
  endtask
  initial begin
    logic [15:0] pick[4];
    bit gap[7];
    step(0, 0, 16'h0, 0);
    step(0, 1, 16'h1234, 1);
    check("reset_c", 32'(c0), 32'h0);
    check("reset_rdy", 32'(snd_rdy0), 32'h1);
    group4(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    check("basic_c", 32'(c0), 32'h0280);
    check("basic_val", 32'(rcv_val0), 32'h1);
    check("basic_rdy", 32'(snd_rdy0), 32'h0);
    step(1, 0, 16'h0, 1);
    check("basic_rdy_back", 32'(snd_rdy0), 32'h1);
    group4(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    for (int i = 0; i < 5; i++) step(1, 1, 16'h7777, 0);
    check("bp_hold_c", 32'(c0), 32'h0280);
    check("bp_hold_rdy", 32'(snd_rdy0), 32'h0);
    step(1, 1, 16'h7777, 1);
    check("bp_release_rdy", 32'(snd_rdy0), 32'h1);
    group4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    check("bp_next_c", 32'(c0), 32'h0400);
    step(1, 0, 16'h0, 1);
    group4(16'h7000, 16'h7000, 16'h7000, 16'h7000);
`ifdef FPACCUM_SATURATE_EN
    check("ovf_pos", 32'(c0), 32'h7FFF);
`else
    check("ovf_pos", 32'(c0), 32'hC000);
`endif
    step(1, 0, 16'h0, 1);
    group4(16'h9000, 16'h9000, 16'h9000, 16'h9000);
`ifdef FPACCUM_SATURATE_EN
    check("ovf_neg", 32'(c0), 32'h8000);
`else
    check("ovf_neg", 32'(c0), 32'h4000);
`endif
    step(1, 0, 16'h0, 1);
    step(1, 1, 16'h0100, 1);
    step(1, 1, 16'h0100, 1);
    step(0, 0, 16'h0, 1);
    check("mid_reset_c", 32'(c0), 32'h0);
    check("mid_reset_rdy", 32'(snd_rdy0), 32'h1);
    group4(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    check("mid_reset_sum", 32'(c0), 32'h0400);
    step(1, 0, 16'h0, 1);
    group4(16'h0100, 16'h0100, 16'h0100, 16'hFFFF);
    check("avg_pos", 32'(c1), 32'h00BF);
    step(1, 0, 16'h0, 1);
    group4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    check("avg_floor", 32'(c1), 32'hFFFF);
    step(1, 0, 16'h0, 1);
    gap = '{1, 0, 0, 1, 0, 1, 1};
    foreach (gap[i]) begin
      step(1, gap[i], 16'h0010, 1);
      check("gap_val", 32'(rcv_val0), 32'(i == 6));
    end
    check("gap_c", 32'(c0), 32'h0040);
    pick = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
    for (int i = 0; i < 600; i++) begin
      logic [15:0] v;
      v = $urandom_range(0, 1) != 0 ? pick[$urandom_range(0, 3)] : 16'($urandom);
      step($urandom_range(0, 60) != 0, $urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
